// File: rtl/adc128s022_scanner.sv
// Free-running SPI (mode 3) scanner for the ADC128S022. Walks the channels set in CHAN_MASK
// round-robin and emits one tagged 12-bit sample per frame.
module adc128s022_scanner #(
  parameter int unsigned SCLK_HALF = 16,
  parameter logic [7:0]  CHAN_MASK = 8'hFF
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        enable,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic        ADC_SADDR,
  input  logic        ADC_SDAT,
  output logic        sample_valid,
  output logic [2:0]  sample_chan,
  output logic [11:0] sample_data,
  output logic        busy
);

  if (SCLK_HALF < 8 || SCLK_HALF > 31) begin : gen_bad_half
    $error("adc128s022_scanner: SCLK_HALF must lie within 8..31");
  end
  if (CHAN_MASK == 8'h00) begin : gen_bad_mask
    $error("adc128s022_scanner: CHAN_MASK must have at least one bit set");
  end

  function automatic logic [2:0] first_chan();
    logic [2:0] res;
    res = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (CHAN_MASK[k]) res = 3'(k);
    end
    return res;
  endfunction

  // Scans downward so the nearest set bit above cur (with wrap) wins; a lone bit maps to itself.
  function automatic logic [2:0] next_chan(input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] cand;
    res = cur;
    for (int k = 7; k >= 1; k--) begin
      cand = cur + 3'(k);
      if (CHAN_MASK[cand]) res = cand;
    end
    return res;
  endfunction

  function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] a);
    logic res;
    case (b)
      4'd2:    res = a[2];
      4'd3:    res = a[1];
      4'd4:    res = a[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  localparam logic [2:0] FirstChan = first_chan();
  localparam logic [4:0] HalfLast  = 5'(SCLK_HALF - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  prev_chan_q, prev_chan_d;
  logic        primed_q, primed_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        saddr_q, saddr_d;
  logic        valid_q, valid_d;
  logic [2:0]  chan_q, chan_d;
  logic [11:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        half_done;

  // The four leading bits of each frame are shifted through but never used.
  logic unused_shift_msb;
  assign unused_shift_msb = shift_q[15];

  assign half_done = (cnt_q == HalfLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 5'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    prev_chan_d = prev_chan_q;
    primed_d    = primed_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    saddr_d     = saddr_q;
    valid_d     = 1'b0;
    chan_d      = chan_q;
    data_d      = data_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 5'd0;
        if (enable) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
        end
      end
      StSetup: begin
        if (half_done) begin
          state_d = StLow;
          cnt_d   = 5'd0;
          bit_d   = 4'd0;
          sclk_d  = 1'b0;
          saddr_d = 1'b0;
        end
      end
      StLow: begin
        if (half_done) begin
          // Sample DOUT on the clock just before SCLK rises.
          state_d = StHigh;
          cnt_d   = 5'd0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[14:0], ADC_SDAT};
        end
      end
      StHigh: begin
        if (half_done) begin
          cnt_d = 5'd0;
          if (bit_q == 4'd15) begin
            state_d     = StHold;
            cs_n_d      = 1'b1;
            valid_d     = primed_q;
            if (primed_q) begin
              chan_d = prev_chan_q;
              data_d = shift_q[11:0];
            end
            primed_d    = 1'b1;
            prev_chan_d = addr_q;
            addr_d      = next_chan(addr_q);
          end else begin
            state_d = StLow;
            sclk_d  = 1'b0;
            bit_d   = bit_q + 4'd1;
            saddr_d = addr_bit(bit_q + 4'd1, addr_q);
          end
        end
      end
      StHold: begin
        if (half_done) begin
          cnt_d = 5'd0;
          if (enable) begin
            state_d = StSetup;
            cs_n_d  = 1'b0;
          end else begin
            state_d  = StIdle;
            primed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        saddr_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      bit_q       <= 4'd0;
      shift_q     <= 16'd0;
      addr_q      <= FirstChan;
      prev_chan_q <= FirstChan;
      primed_q    <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      saddr_q     <= 1'b0;
      valid_q     <= 1'b0;
      chan_q      <= 3'd0;
      data_q      <= 12'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      prev_chan_q <= prev_chan_d;
      primed_q    <= primed_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      saddr_q     <= saddr_d;
      valid_q     <= valid_d;
      chan_q      <= chan_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_SADDR    = saddr_q;
  assign sample_valid = valid_q;
  assign sample_chan  = chan_q;
  assign sample_data  = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc128s022_scanner.sv
// Bench for adc128s022_scanner: full-mask and two-channel instances, each with an ADC model
// (mode 3, one-frame address pipeline) feeding a scoreboard of expected samples.
module tb_adc128s022_scanner;

  localparam int Half = 16;
  localparam int Tclk = 20;
  localparam int WaitLimit = 20000;

  typedef struct {
    logic [2:0]  chan;
    logic [11:0] data;
    logic        chained;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] vals [8];
  logic [3:0]  top_nib;
  int          n_checks = 0;
  int          n_errors = 0;

  initial forever #(Tclk / 2) clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] tb_first(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [2:0] tb_next(input logic [7:0] m, input logic [2:0] c);
    for (int i = 1; i <= 8; i++) if (m[3'(int'(c) + i)]) return 3'(int'(c) + i);
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam logic [7:0] Mask = (g == 0) ? 8'hFF : 8'b0010_0100;

    logic        cs_n, sclk, saddr, valid, busy;
    logic        sdat = 1'b0;
    logic [2:0]  chan;
    logic [11:0] data;

    adc128s022_scanner #(
      .SCLK_HALF(Half),
      .CHAN_MASK(Mask)
    ) u_dut (
      .CLOCK_50    (clk),
      .rst         (rst),
      .enable      (enable),
      .ADC_CS_N    (cs_n),
      .ADC_SCLK    (sclk),
      .ADC_SADDR   (saddr),
      .ADC_SDAT    (sdat),
      .sample_valid(valid),
      .sample_chan (chan),
      .sample_data (data),
      .busy        (busy)
    );

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0, ridx = 0, nframes = 0, npop = 0;
    int          t_rise = 0, t_csr = -100, t_valid = 0;
    logic        pcs = 1'b1, psclk = 1'b1, psaddr = 1'b0, primed = 1'b0, chained = 1'b0;
    logic [2:0]  din_addr = '0, adc_prev = '0, exp_addr = '0, prev_exp = '0;
    logic [15:0] word = '0;

    // Everything is sampled on the falling system-clock edge; edges are found by comparison.
    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        q.delete();
        primed   = 1'b0;
        chained  = 1'b0;
        ridx     = 0;
        exp_addr = tb_first(Mask);
      end else begin
        if (saddr !== psaddr) check_eq("saddr_change_on_sclk_fall", psclk && !sclk, 1);
        if (pcs && !cs_n) begin
          nframes++;
          check_eq("sclk_high_at_cs_fall", sclk, 1);
          check_eq("cs_high_gap_min", (cyc - t_csr) >= 16, 1);
          ridx = 0;
          word = {top_nib, vals[adc_prev]};
          sdat = word[15];
          if (primed) q.push_back('{chan: prev_exp, data: vals[prev_exp], chained: chained});
          chained = primed;
          primed  = 1'b1;
        end
        if (!cs_n && psclk && !sclk && ridx < 16) sdat = word[4'(15 - ridx)];
        if (!cs_n && !psclk && sclk) begin
          if (ridx > 0) check_eq("sclk_period", cyc - t_rise, 2 * Half);
          t_rise = cyc;
          if (ridx >= 2 && ridx <= 4) din_addr[3'(4 - ridx)] = saddr;
          ridx++;
        end
        if (!pcs && cs_n) begin
          check_eq("sclk_high_at_cs_rise", sclk, 1);
          check_eq("sclk_rises_per_frame", ridx, 16);
          check_eq("saddr_chan", din_addr, exp_addr);
          t_csr    = cyc;
          adc_prev = din_addr;
          prev_exp = exp_addr;
          exp_addr = tb_next(Mask, exp_addr);
          if (!enable) primed = 1'b0;
        end
        if (valid) begin
          check_eq("strobe_expected", q.size() > 0, 1);
          check_eq("cs_high_at_strobe", cs_n, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check_eq("sample_chan", chan, e.chan);
            check_eq("sample_data", data, e.data);
            if (e.chained) check_eq("strobe_spacing", cyc - t_valid, 34 * Half);
            t_valid = cyc;
            npop++;
          end
        end
      end
      pcs    = cs_n;
      psclk  = sclk;
      psaddr = saddr;
    end
  end

  task automatic wait_bit(input int frame, input int bitn);
    int n;
    n = 0;
    while (!(gen_dut[0].nframes == frame && gen_dut[0].ridx == bitn) && n < WaitLimit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("wait_frame_bit_bound", n < WaitLimit, 1);
  endtask

  task automatic wait_cs_high();
    int n;
    n = 0;
    while (gen_dut[0].cs_n == 1'b0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("wait_cs_high_bound", n < 2000, 1);
  endtask

  task automatic check_outputs_reset(input string tag);
    check_eq({tag, "_cs_n0"}, gen_dut[0].cs_n, 1);
    check_eq({tag, "_sclk0"}, gen_dut[0].sclk, 1);
    check_eq({tag, "_saddr0"}, gen_dut[0].saddr, 0);
    check_eq({tag, "_valid0"}, gen_dut[0].valid, 0);
    check_eq({tag, "_chan0"}, gen_dut[0].chan, 0);
    check_eq({tag, "_data0"}, gen_dut[0].data, 0);
    check_eq({tag, "_busy0"}, gen_dut[0].busy, 0);
    check_eq({tag, "_cs_n1"}, gen_dut[1].cs_n, 1);
    check_eq({tag, "_chan1"}, gen_dut[1].chan, 0);
    check_eq({tag, "_data1"}, gen_dut[1].data, 0);
    check_eq({tag, "_busy1"}, gen_dut[1].busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vals[i] = 12'(i * 12'h111);
    top_nib = 4'h0;
    rst     = 1'b1;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    #1;
    check_eq("cs_fall_after_enable", gen_dut[0].cs_n, 0);
    check_eq("busy_in_frame", gen_dut[0].busy, 1);

    // Drop enable mid-frame; that frame must still complete and strobe.
    wait_bit(11, 7);
    enable = 1'b0;
    wait_cs_high();
    repeat (2 * Half) @(negedge clk);
    #1;
    check_eq("idle_busy0", gen_dut[0].busy, 0);
    check_eq("idle_busy1", gen_dut[1].busy, 0);
    check_eq("idle_cs_n0", gen_dut[0].cs_n, 1);

    // Leading bits driven high must not leak into the sample.
    top_nib = 4'hF;
    vals[3] = 12'hABC;
    vals[5] = 12'hABC;
    enable  = 1'b1;
    @(negedge clk);
    #1;
    check_eq("cs_fall_after_reenable", gen_dut[0].cs_n, 0);

    wait_bit(16, 9);
    rst = 1'b1;
    #1;
    check_outputs_reset("rst_mid_frame");
    @(negedge clk);
    #1;
    rst = 1'b0;

    wait_bit(19, 1);
    enable = 1'b0;
    wait_cs_high();
    repeat (2 * Half) @(negedge clk);
    #1;
    check_eq("queue_drained0", gen_dut[0].q.size(), 0);
    check_eq("queue_drained1", gen_dut[1].q.size(), 0);
    check_eq("strobe_count0", gen_dut[0].npop, 15);
    check_eq("strobe_count1", gen_dut[1].npop, 15);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
